// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter: address width, FSM
// encoding, owner IDs and the starvation-counter width helper.
package fb_pkg;

  localparam int FB_ADDR_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    FSM_IDLE  = ST_IDLE,
    FSM_ISSUE = ST_ISSUE,
    FSM_RESP  = ST_RESP
  } fb_state_e;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_DISP = 1'b1;

  // Bits needed to count 0..limit inclusive.
  function automatic int fb_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/fb_pick.sv
// Winner select between CPU and display plus the CPU starvation counter.
// The counter only moves on arbitration cycles and is cleared whenever the
// CPU is not asking, so it measures consecutive losses of one request.
module fb_pick
  import fb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic window,
  input  logic cpu_req,
  input  logic disp_req,
  output logic grant_valid,
  output logic grant_own
);

  localparam int CNT_W = fb_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Winner select: display has priority only inside the frame window and
  // only while the CPU has not yet hit the starvation limit.
  always_comb begin
    grant_valid = 1'b0;
    grant_own   = OWN_CPU;
    if (cpu_req && disp_req) begin
      grant_valid = 1'b1;
      if (window && (starve_q != LIMIT_C)) begin
        grant_own = OWN_DISP;
      end else begin
        grant_own = OWN_CPU;
      end
    end else if (cpu_req) begin
      grant_valid = 1'b1;
      grant_own   = OWN_CPU;
    end else if (disp_req) begin
      grant_valid = 1'b1;
      grant_own   = OWN_DISP;
    end else begin
      grant_valid = 1'b0;
    end
  end

  // Starvation counter next value: count CPU losses, saturate at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_req) begin
      starve_d = {CNT_W{1'b0}};
    end else if (arb_en && (grant_own == OWN_CPU)) begin
      starve_d = {CNT_W{1'b0}};
    end else if (arb_en && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter between the CPU and the OLED screen bridge.
// Three-state access FSM (IDLE/ISSUE/RESP), a 60 Hz frame window that gives
// the display priority, and a sticky overrun flag for late frames.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_60hz,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_busy,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_done,
  output logic              disp_ack,
  output logic [7:0]        disp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              overrun
);

  fb_state_e         state_q, state_d;
  logic              own_q, own_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              disp_ack_q, disp_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        disp_rdata_q, disp_rdata_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic arb_en;
  logic grant_valid;
  logic grant_own;

  assign arb_en = (state_q == FSM_IDLE);

  fb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .arb_en     (arb_en),
    .window     (busy_q),
    .cpu_req    (cpu_req),
    .disp_req   (disp_req),
    .grant_valid(grant_valid),
    .grant_own  (grant_own)
  );

  // Access FSM: latch the winner into the RAM drive registers, raise the
  // ack during RESP and keep the last returned byte per requester.
  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    disp_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    disp_rdata_d = disp_rdata_q;
    case (state_q)
      FSM_IDLE: begin
        if (grant_valid) begin
          state_d  = FSM_ISSUE;
          own_d    = grant_own;
          mem_en_d = 1'b1;
          if (grant_own == OWN_DISP) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = disp_addr;
            mem_wdata_d = 8'h00;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end else begin
          state_d = FSM_IDLE;
        end
      end
      FSM_ISSUE: begin
        state_d = FSM_RESP;
        if (own_q == OWN_DISP) begin
          disp_ack_d = 1'b1;
        end else begin
          cpu_ack_d = 1'b1;
        end
      end
      FSM_RESP: begin
        state_d = FSM_IDLE;
        if (own_q == OWN_DISP) begin
          disp_rdata_d = mem_rdata;
        end else begin
          cpu_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = FSM_IDLE;
      end
    endcase
  end

  // Frame window and overrun: a tick coinciding with disp_done is a clean
  // close-and-reopen, any other tick while open is a late frame.
  always_comb begin
    busy_d    = busy_q;
    overrun_d = overrun_q;
    if (tick_60hz) begin
      busy_d = 1'b1;
      if (busy_q && !disp_done) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (disp_done) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // State and output registers; reset drops any latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FSM_IDLE;
      own_q        <= OWN_CPU;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= 8'h00;
      cpu_ack_q    <= 1'b0;
      disp_ack_q   <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      disp_rdata_q <= 8'h00;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      disp_ack_q   <= disp_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      disp_rdata_q <= disp_rdata_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign disp_ack  = disp_ack_q;
  assign cpu_busy  = busy_q;
  assign overrun   = overrun_q;

  // The RAM returns data during RESP, the same cycle as the ack, so the
  // winner sees mem_rdata directly then and the held copy afterwards.
  assign cpu_rdata  = (state_q == FSM_RESP && own_q == OWN_CPU)  ? mem_rdata : cpu_rdata_q;
  assign disp_rdata = (state_q == FSM_RESP && own_q == OWN_DISP) ? mem_rdata : disp_rdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: a behavioural RAM, a shadow memory
// scoreboard and a grant-order reference model built from the arbitration
// rules, driven with randomized addresses and data.
module tb_fb_arbiter;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_60hz = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic       disp_req = 1'b0;
  logic [7:0] disp_addr = 8'h00;
  logic       disp_done = 1'b0;
  logic       cpu_ack, cpu_busy, disp_ack, mem_en, mem_we, overrun;
  logic [7:0] cpu_rdata, disp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] ram [256];
  logic [7:0] shadow [256];
  bit         known [256];
  logic [7:0] wr_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  fb_arbiter #(.ADDR_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .tick_60hz(tick_60hz),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_done(disp_done),
    .disp_ack(disp_ack), .disp_rdata(disp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({cpu_ack, disp_ack, mem_en, mem_we, cpu_busy, overrun}), 32'(0));
    check({tag, "_data"}, {cpu_rdata, disp_rdata, mem_addr, mem_wdata}, 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [7:0] pick();
    return wr_q[$urandom_range(0, wr_q.size() - 1)];
  endfunction

  // Reference arbitration rule with display always pending; returns 1 when
  // the display should win and tracks consecutive CPU losses.
  function automatic logic ref_disp_wins(input logic window, input logic cpu_on, inout int losses);
    logic win_disp;
    if (!cpu_on) win_disp = 1'b1;
    else if (window && losses < LIMIT) win_disp = 1'b1;
    else win_disp = 1'b0;
    if (cpu_on && win_disp) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
    else losses = 0;
    return win_disp;
  endfunction

  task automatic cpu_xfer(input logic we, input logic [7:0] a, input logic [7:0] d, input string tag);
    int lat = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    while (cpu_ack !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(2));
    if (cpu_ack === 1'b1) begin
      if (we) begin
        shadow[a] = d;
        if (!known[a]) begin known[a] = 1'b1; wr_q.push_back(a); end
      end else begin
        check({tag, "_rd"}, 32'(cpu_rdata), 32'(shadow[a]));
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
  endtask

  task automatic disp_xfer(input logic [7:0] a, input string tag);
    int lat = 0;
    disp_req = 1'b1; disp_addr = a;
    while (disp_ack !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(2));
    if (disp_ack === 1'b1) check({tag, "_rd"}, 32'(disp_rdata), 32'(shadow[a]));
    disp_req = 1'b0;
    step();
  endtask

  // Both requesters hold their requests; every grant is checked against the
  // reference rule and the data against the shadow memory.
  task automatic run_both(input int n_grants, input logic window, input int drop_cpu_at, input string tag);
    int   losses = 0;
    int   got = 0;
    int   cyc = 0;
    logic cpu_on = 1'b1;
    logic exp_disp;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = pick();
    disp_req = 1'b1; disp_addr = pick();
    while (got < n_grants && cyc < 300) begin
      step();
      cyc++;
      if (mem_en === 1'b1) check({tag, "_rd_only"}, 32'(mem_we), 32'(0));
      if (cpu_ack === 1'b1 || disp_ack === 1'b1) begin
        exp_disp = ref_disp_wins(window, cpu_on, losses);
        check($sformatf("%s_grant%0d", tag, got), 32'(disp_ack), 32'(exp_disp));
        if (disp_ack === 1'b1) check({tag, "_drd"}, 32'(disp_rdata), 32'(shadow[disp_addr]));
        else check({tag, "_crd"}, 32'(cpu_rdata), 32'(shadow[cpu_addr]));
        got++;
        cpu_addr = pick();
        disp_addr = pick();
        if (got == drop_cpu_at) begin cpu_req = 1'b0; cpu_on = 1'b0; end
      end
    end
    check({tag, "_count"}, 32'(got), 32'(n_grants));
    cpu_req = 1'b0; disp_req = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int         kind;
    do_reset();

    // Lone CPU write then read with exact cycle timing.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    step();
    check("t1_mem_en_we", 32'({mem_en, mem_we}), 32'(2'b11));
    check("t1_addr_data", 32'({mem_addr, mem_wdata}), 32'(16'h10A5));
    check("t1_noack_yet", 32'(cpu_ack), 32'(0));
    step();
    check("t1_ack", 32'(cpu_ack), 32'(1));
    check("t1_en_off", 32'(mem_en), 32'(0));
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    shadow[8'h10] = 8'hA5; known[8'h10] = 1'b1; wr_q.push_back(8'h10);
    cpu_xfer(1'b0, 8'h10, 8'h00, "t1_read");
    repeat (3) step();
    check("t1_rdata_held", 32'(cpu_rdata), 32'(8'hA5));

    // Randomized lone traffic from both sides, window closed.
    for (int i = 0; i < 30; i++) begin
      kind = (i < 6) ? 0 : int'($urandom_range(0, 2));
      if (kind == 0) cpu_xfer(1'b1, 8'($urandom), 8'($urandom), "rnd_cw");
      else if (kind == 1) cpu_xfer(1'b0, pick(), 8'h00, "rnd_cr");
      else disp_xfer(pick(), "rnd_dr");
      repeat ($urandom_range(0, 2)) step();
    end

    // Frame window open: display priority with bounded CPU starvation.
    check("win_closed", 32'(cpu_busy), 32'(0));
    tick_60hz = 1'b1; step(); tick_60hz = 1'b0;
    check("win_open", 32'(cpu_busy), 32'(1));
    check("win_no_ovr", 32'(overrun), 32'(0));
    run_both(15, 1'b1, 0, "win");
    check("win_hold", 32'(cpu_busy), 32'(1));
    disp_done = 1'b1; step(); disp_done = 1'b0;
    check("win_close", 32'(cpu_busy), 32'(0));

    // Window closed: CPU wins until it drops its request.
    run_both(8, 1'b0, 6, "cls");

    // Second tick before disp_done sets a sticky overrun.
    tick_60hz = 1'b1; step(); tick_60hz = 1'b0;
    check("ovr_open", 32'(cpu_busy), 32'(1));
    repeat (3) step();
    tick_60hz = 1'b1; step(); tick_60hz = 1'b0;
    check("ovr_set", 32'({cpu_busy, overrun}), 32'(2'b11));
    repeat (5) step();
    check("ovr_stay", 32'({cpu_busy, overrun}), 32'(2'b11));
    disp_done = 1'b1; step(); disp_done = 1'b0;
    check("ovr_close", 32'({cpu_busy, overrun}), 32'(2'b01));
    step();
    check("ovr_sticky", 32'(overrun), 32'(1));

    // Tick and disp_done together: window stays open, no overrun.
    do_reset();
    check("same_ovr_rst", 32'(overrun), 32'(0));
    tick_60hz = 1'b1; step(); tick_60hz = 1'b0;
    repeat (2) step();
    tick_60hz = 1'b1; disp_done = 1'b1; step(); tick_60hz = 1'b0; disp_done = 1'b0;
    check("same_busy", 32'({cpu_busy, overrun}), 32'(2'b10));
    step();
    check("same_busy2", 32'({cpu_busy, overrun}), 32'(2'b10));
    disp_done = 1'b1; step(); disp_done = 1'b0;
    check("same_close", 32'(cpu_busy), 32'(0));

    // Reset during ISSUE of a CPU read; request is re-served afterwards.
    a = pick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    step();
    check("rst_in_issue", 32'(mem_en), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    step();
    check("rst_no_ack", 32'(cpu_ack), 32'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    cpu_xfer(1'b0, a, 8'h00, "rst_reserve");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares the single-port 256-byte CHIP-8 framebuffer RAM between the CPU (draw/clear, read-modify-write) and the OLED screen bridge (frame readout). Opens a display frame window on each 60 Hz tick, gives the display priority inside the window and bounds CPU starvation. Sits between `cpu`, `screen_bridge` and the framebuffer RAM, and replaces the ad-hoc `scr_busy` coupling.

## Interface
- `ADDR_W`, default 8: framebuffer byte address width (64x32 bits = 256 bytes).
- `STARVE_LIMIT`, default 4: consecutive CPU arbitration losses after which the CPU wins the next arbitration.
- `clk`  in  1  system clock (16 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick_60hz`  in  1  one-cycle frame-start strobe.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr`  in  ADDR_W  byte address; stable while `cpu_req`.
- `cpu_wdata`  in  8  write data; stable while `cpu_req`.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read data, valid with `cpu_ack`, held until the next CPU ack.
- `cpu_busy`  out  1  display frame window open.
- `disp_req`  in  1  display read request; held until `disp_ack`.
- `disp_addr`  in  ADDR_W  display read address.
- `disp_done`  in  1  one-cycle pulse; frame readout finished.
- `disp_ack`  out  1  one-cycle completion pulse.
- `disp_rdata`  out  8  read data, valid with `disp_ack`.
- `mem_en`, `mem_we`  out  1  RAM strobe / write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  8  RAM write data.
- `mem_rdata`  in  8  RAM read data, one cycle after `mem_en`.
- `overrun`  out  1  sticky flag: `tick_60hz` arrived while a frame window was open.

## Operation
- FSM states:
  - IDLE: arbitrate when any request is pending. The winner's request fields are latched, go to ISSUE.
  - ISSUE: registered `mem_en`=1. `mem_we`/`mem_addr`/`mem_wdata` come from the latch. Go to RESP.
  - RESP: capture `mem_rdata` into the winner's rdata register, pulse the winner's ack. Go to IDLE.
- Display requests are always read-only; `mem_we`=0 for them.
- Arbitration in IDLE, both requests pending:
  - Frame window open: display wins, unless `starve_cnt` == `STARVE_LIMIT`, in which case the CPU wins.
  - Frame window closed: CPU wins.
- Single pending request: that requester wins.
- `starve_cnt`:
  - Increments when the CPU loses with `cpu_req` high.
  - Clears when the CPU wins or `cpu_req` is low.
  - Saturates at `STARVE_LIMIT`.
- Frame window (`cpu_busy`):
  - Set the cycle after `tick_60hz`.
  - Cleared the cycle after `disp_done`.
  - Display requests are served outside the window too, at CPU priority.
- Boundary conditions:
  - `tick_60hz` while window open: window stays open and `overrun` sets. `overrun` is cleared only by reset.
  - `tick_60hz` and `disp_done` in the same cycle: the window closes and reopens, so it stays 1. `overrun` is not set.
  - Address width: `mem_addr` is exactly ADDR_W bits, no wrap logic. Requesters own address range.
- Reset mid-operation:
  - Asynchronously drives all outputs low.
  - State returns to IDLE; any latched request is dropped and the requester re-presents it.
  - A write already strobed into RAM before reset stands.

## Timing
- Reset values: `cpu_ack`, `disp_ack`, `mem_en`, `mem_we`, `cpu_busy`, `overrun` = 0. `cpu_rdata`, `disp_rdata`, `mem_addr`, `mem_wdata` = 0. `starve_cnt` = 0.
- Request sampled high in IDLE at edge N:
  - `mem_en` high in cycle N+1.
  - ack and rdata valid in cycle N+2.
  - Requester may drop or change its request at edge N+3.
- Throughput: one access per 3 cycles. Back-to-back accesses from the same requester are allowed; re-arbitration occurs every IDLE.
- A request still high in the ack cycle is treated as a new request.

## Structure
- Shared package `fb_pkg`:
  - `FB_ADDR_W` = 8.
  - State encoding localparams `ST_IDLE`/`ST_ISSUE`/`ST_RESP`.
  - Owner IDs `OWN_CPU`/`OWN_DISP`.
- One natural sub-module, `fb_pick`: the combinational winner select plus the `starve_cnt` register, parameterised by `STARVE_LIMIT`.
- FSM, latch, frame window and RAM drive stay in `fb_arbiter`.

## Test plan
- Lone CPU write addr 0x10 data 0xA5, then read 0x10 -> `mem_we`=1 at N+1, `cpu_ack` at N+2, read returns `cpu_rdata`=0xA5 at its N+2.
- `tick_60hz`, then both requesting continuously -> order D,D,D,D,C,D,D,D,D,C…; no request waits beyond 5 arbitrations.
- Both requesting, window closed -> CPU wins every arbitration; `disp_ack` only once `cpu_req` drops.
- Second `tick_60hz` before `disp_done` -> `overrun`=1 and stays 1; `cpu_busy` stays 1 until `disp_done`+1.
- `tick_60hz` and `disp_done` in the same cycle -> `cpu_busy` stays 1, `overrun`=0.
- `rst_n` low during ISSUE of a CPU read -> all outputs 0 immediately; no `cpu_ack`; request re-served normally after release.
